// File: rtl/prga_fifo_pkg.sv
// Shared FIFO helpers: derived widths used by the narrow-to-wide packer.
package prga_fifo_pkg;

  function automatic int packer_out_width(input int data_width, input int multiplier);
    return data_width * multiplier;
  endfunction

  function automatic int packer_cnt_width(input int multiplier);
    return (multiplier <= 2) ? 1 : $clog2(multiplier);
  endfunction

endpackage

// File: rtl/prga_fifo_lookahead_buffer.sv
// Turns a non-lookahead FIFO read port (data one cycle after rd_i) into a
// lookahead port (dout valid whenever !empty), sustaining one word per cycle.
module prga_fifo_lookahead_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty_i,
  output logic                  rd_i,
  input  logic [DATA_WIDTH-1:0] dout_i,
  output logic                  empty,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout
);

  logic                  r_pend;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_take;

  // At most one word is ever in flight or held, so a new read is issued only
  // when nothing will remain after this cycle's consume.
  assign empty  = !(r_pend || r_valid);
  assign dout   = r_valid ? r_data : dout_i;
  assign w_take = rd && !empty;
  assign rd_i   = !rst && !empty_i && (empty || w_take);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_pend <= rd_i;
      if (r_pend && !w_take) begin
        r_valid <= 1'b1;
        r_data  <= dout_i;
      end else if (w_take) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/prga_fifo_packer.sv
// Packs MULTIPLIER narrow upstream words (LSB-first) into one wide word and
// pushes it into a downstream FIFO; a flush pulse emits a zero-padded partial word.
module prga_fifo_packer
  import prga_fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int MULTIPLIER      = 4,
  parameter bit INPUT_LOOKAHEAD = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             empty_i,
  output logic                             rd_i,
  input  logic [DATA_WIDTH-1:0]            dout_i,
  input  logic                             full,
  output logic                             wr,
  output logic [DATA_WIDTH*MULTIPLIER-1:0] din,
  input  logic                             flush
);

  localparam int OUT_WIDTH = packer_out_width(DATA_WIDTH, MULTIPLIER);
  localparam int CNT_WIDTH = packer_cnt_width(MULTIPLIER);
  localparam logic [CNT_WIDTH-1:0] LAST_SLOT = CNT_WIDTH'(MULTIPLIER - 1);

  logic                  w_empty;
  logic                  w_rd;
  logic [DATA_WIDTH-1:0] w_dout;

  generate
    if (INPUT_LOOKAHEAD == 1'b0) begin : g_buf
      prga_fifo_lookahead_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .empty_i(empty_i),
        .rd_i   (rd_i),
        .dout_i (dout_i),
        .empty  (w_empty),
        .rd     (w_rd),
        .dout   (w_dout)
      );
    end else begin : g_direct
      assign w_empty = empty_i;
      assign w_dout  = dout_i;
      assign rd_i    = w_rd;
    end
  endgenerate

  logic                 r_wr;
  logic [OUT_WIDTH-1:0] r_din;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [OUT_WIDTH-1:0] r_coll;
  logic                 r_flush_pending;

  logic                 w_last;
  logic                 w_out_free;
  logic                 w_accept;
  logic                 w_flush_move;
  logic [OUT_WIDTH-1:0] w_coll_next;

  assign w_last       = (r_cnt == LAST_SLOT);
  assign w_out_free   = !r_wr || !full;
  // Only the group-completing word needs room in the output register.
  assign w_accept     = !rst && !r_flush_pending && (!w_last || w_out_free);
  assign w_rd         = w_accept && !w_empty;
  assign w_flush_move = r_flush_pending && (r_cnt != '0) && w_out_free;

  always_comb begin
    w_coll_next = r_coll;
    for (int k = 0; k < MULTIPLIER; k++) begin
      if (r_cnt == CNT_WIDTH'(k)) w_coll_next[k*DATA_WIDTH +: DATA_WIDTH] = w_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr            <= 1'b0;
      r_din           <= '0;
      r_cnt           <= '0;
      r_coll          <= '0;
      r_flush_pending <= 1'b0;
    end else begin
      if (w_rd && w_last) begin
        r_wr  <= 1'b1;
        r_din <= w_coll_next;
      end else if (w_flush_move) begin
        r_wr  <= 1'b1;
        r_din <= r_coll;
      end else if (r_wr && !full) begin
        r_wr <= 1'b0;
      end

      // Collector is cleared whenever it is handed off so unfilled slots read as zero.
      if (w_rd) begin
        r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
        r_coll <= w_last ? '0 : w_coll_next;
      end else if (w_flush_move) begin
        r_cnt  <= '0;
        r_coll <= '0;
      end

      if (r_flush_pending) begin
        if ((r_cnt == '0) || w_flush_move) r_flush_pending <= 1'b0;
      end else if (flush) begin
        r_flush_pending <= 1'b1;
      end
    end
  end

  assign wr  = r_wr;
  assign din = r_din;

endmodule

// File: tb/tb_prga_fifo_packer.sv
// Directed bench: one lookahead and one non-lookahead packer fed from the same
// byte table, with per-scenario tasks checking captured downstream writes.
module tb_prga_fifo_packer;

  localparam int DW = 8;
  localparam int M  = 4;
  localparam int OW = DW * M;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, full, flush;
  logic [DW-1:0] src [0:63];
  int src_len;
  int la_ptr, nl_ptr;
  int cyc = 0;
  int errors, checks;

  logic          empty_la, rd_la, wr_la;
  logic          empty_nl, rd_nl, wr_nl;
  logic [DW-1:0] dout_la, dout_nl;
  logic [OW-1:0] din_la, din_nl;

  logic [OW-1:0] q_la[$], q_nl[$];
  int            t_la[$], t_nl[$], rdq_la[$];

  prga_fifo_packer #(.DATA_WIDTH(DW), .MULTIPLIER(M), .INPUT_LOOKAHEAD(1'b1)) dut_la (
    .clk(clk), .rst(rst), .empty_i(empty_la), .rd_i(rd_la), .dout_i(dout_la),
    .full(full), .wr(wr_la), .din(din_la), .flush(flush));

  prga_fifo_packer #(.DATA_WIDTH(DW), .MULTIPLIER(M), .INPUT_LOOKAHEAD(1'b0)) dut_nl (
    .clk(clk), .rst(rst), .empty_i(empty_nl), .rd_i(rd_nl), .dout_i(dout_nl),
    .full(full), .wr(wr_nl), .din(din_nl), .flush(flush));

  // Upstream FIFO models: lookahead presents the head word combinationally,
  // non-lookahead returns the popped word on the cycle after rd_i.
  assign empty_la = (la_ptr >= src_len);
  assign empty_nl = (nl_ptr >= src_len);
  assign dout_la  = src[la_ptr[5:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      la_ptr  <= 0;
      nl_ptr  <= 0;
      dout_nl <= '0;
    end else begin
      if (rd_la && !empty_la) la_ptr <= la_ptr + 1;
      if (rd_nl && !empty_nl) begin
        dout_nl <= src[nl_ptr[5:0]];
        nl_ptr  <= nl_ptr + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (wr_la && !full) begin q_la.push_back(din_la); t_la.push_back(cyc); end
    if (wr_nl && !full) begin q_nl.push_back(din_nl); t_nl.push_back(cyc); end
    if (rd_la && !empty_la) rdq_la.push_back(cyc);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    full = 1'b0;
    flush = 1'b0;
    src_len = 0;
    step(1);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) src[i] = DW'(8'h50 + i);
    src_len = 4;
    #1;
    checks++; if (wr_la !== 1'b0) begin errors++; $display("FAIL reset_wr_la: got %b want 0", wr_la); end
    checks++; if (din_la !== '0) begin errors++; $display("FAIL reset_din_la: got %h want 0", din_la); end
    checks++; if (rd_la !== 1'b0) begin errors++; $display("FAIL reset_rd_la: got %b want 0", rd_la); end
    checks++; if (wr_nl !== 1'b0) begin errors++; $display("FAIL reset_wr_nl: got %b want 0", wr_nl); end
    checks++; if (din_nl !== '0) begin errors++; $display("FAIL reset_din_nl: got %h want 0", din_nl); end
    checks++; if (rd_nl !== 1'b0) begin errors++; $display("FAIL reset_rd_nl: got %b want 0", rd_nl); end
  endtask

  task automatic test_stream();
    int bl, bn, br, st;
    logic [OW-1:0] w0, w1;
    do_reset();
    for (int i = 0; i < 8; i++) src[i] = DW'(i + 1);
    bl = q_la.size(); bn = q_nl.size(); br = rdq_la.size();
    src_len = 8;
    rst = 1'b0;
    st = cyc;
    step(14);
    checks++; if (q_la.size() - bl != 2) begin errors++; $display("FAIL stream_la_count: got %0d want 2", q_la.size() - bl); end
    w0 = (q_la.size() > bl) ? q_la[bl] : '0;
    w1 = (q_la.size() > bl + 1) ? q_la[bl+1] : '0;
    checks++; if (w0 !== 32'h04030201) begin errors++; $display("FAIL stream_la_w0: got %h want 04030201", w0); end
    checks++; if (w1 !== 32'h08070605) begin errors++; $display("FAIL stream_la_w1: got %h want 08070605", w1); end
    checks++; if (((t_la.size() > bl) ? t_la[bl] : -1) != st + 4) begin errors++; $display("FAIL stream_la_lat: got %0d want %0d", (t_la.size() > bl) ? t_la[bl] - st : -1, 4); end
    checks++; if (q_nl.size() - bn != 2) begin errors++; $display("FAIL stream_nl_count: got %0d want 2", q_nl.size() - bn); end
    w0 = (q_nl.size() > bn) ? q_nl[bn] : '0;
    w1 = (q_nl.size() > bn + 1) ? q_nl[bn+1] : '0;
    checks++; if (w0 !== 32'h04030201) begin errors++; $display("FAIL stream_nl_w0: got %h want 04030201", w0); end
    checks++; if (w1 !== 32'h08070605) begin errors++; $display("FAIL stream_nl_w1: got %h want 08070605", w1); end
    checks++; if (((t_nl.size() > bn) ? t_nl[bn] : -1) != st + 5) begin errors++; $display("FAIL stream_nl_lat: got %0d want %0d", (t_nl.size() > bn) ? t_nl[bn] - st : -1, 5); end
    checks++; if (rdq_la.size() - br != 8) begin errors++; $display("FAIL stream_rd_count: got %0d want 8", rdq_la.size() - br); end
    checks++; if (((rdq_la.size() > br) ? rdq_la[rdq_la.size()-1] - rdq_la[br] : -1) != 7) begin errors++; $display("FAIL stream_rd_span: got %0d want 7", (rdq_la.size() > br) ? rdq_la[rdq_la.size()-1] - rdq_la[br] : -1); end
  endtask

  task automatic test_full();
    int bl, br;
    logic [OW-1:0] w0, w1, w2;
    do_reset();
    for (int i = 0; i < 12; i++) src[i] = DW'(i + 1);
    bl = q_la.size(); br = rdq_la.size();
    full = 1'b1;
    src_len = 12;
    rst = 1'b0;
    step(12);
    checks++; if (wr_la !== 1'b1) begin errors++; $display("FAIL full_hold_wr: got %b want 1", wr_la); end
    checks++; if (din_la !== 32'h04030201) begin errors++; $display("FAIL full_hold_din: got %h want 04030201", din_la); end
    checks++; if (rdq_la.size() - br != 7) begin errors++; $display("FAIL full_rd_stop: got %0d want 7", rdq_la.size() - br); end
    full = 1'b0;
    step(12);
    checks++; if (q_la.size() - bl != 3) begin errors++; $display("FAIL full_release_count: got %0d want 3", q_la.size() - bl); end
    w0 = (q_la.size() > bl) ? q_la[bl] : '0;
    w1 = (q_la.size() > bl + 1) ? q_la[bl+1] : '0;
    w2 = (q_la.size() > bl + 2) ? q_la[bl+2] : '0;
    checks++; if (w0 !== 32'h04030201) begin errors++; $display("FAIL full_w0: got %h want 04030201", w0); end
    checks++; if (w1 !== 32'h08070605) begin errors++; $display("FAIL full_w1: got %h want 08070605", w1); end
    checks++; if (w2 !== 32'h0C0B0A09) begin errors++; $display("FAIL full_w2: got %h want 0c0b0a09", w2); end
    checks++; if (rdq_la.size() - br != 12) begin errors++; $display("FAIL full_rd_total: got %0d want 12", rdq_la.size() - br); end
  endtask

  task automatic test_flush();
    int bl;
    logic [OW-1:0] w0;
    do_reset();
    src[0] = 8'hAA; src[1] = 8'hBB;
    bl = q_la.size();
    src_len = 2;
    rst = 1'b0;
    step(4);
    checks++; if (q_la.size() != bl) begin errors++; $display("FAIL flush_partial_hold: got %0d writes want 0", q_la.size() - bl); end
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(4);
    checks++; if (q_la.size() - bl != 1) begin errors++; $display("FAIL flush_count: got %0d want 1", q_la.size() - bl); end
    w0 = (q_la.size() > bl) ? q_la[bl] : '0;
    checks++; if (w0 !== 32'h0000BBAA) begin errors++; $display("FAIL flush_word: got %h want 0000bbaa", w0); end
    bl = q_la.size();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(4);
    checks++; if (q_la.size() != bl) begin errors++; $display("FAIL flush_empty_nowrite: got %0d writes want 0", q_la.size() - bl); end
    checks++; if (wr_la !== 1'b0) begin errors++; $display("FAIL flush_empty_wr: got %b want 0", wr_la); end
  endtask

  task automatic test_flush_coincident();
    int bl, st;
    logic [OW-1:0] w0, w1;
    do_reset();
    src[0] = 8'hAA; src[1] = 8'hBB; src[2] = 8'hCC; src[3] = 8'hDD;
    src[4] = 8'hEE; src[5] = 8'hFF; src[6] = 8'h11;
    bl = q_la.size();
    src_len = 7;
    rst = 1'b0;
    st = cyc;
    step(2);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(10);
    checks++; if (q_la.size() - bl != 2) begin errors++; $display("FAIL coinc_count: got %0d want 2", q_la.size() - bl); end
    w0 = (q_la.size() > bl) ? q_la[bl] : '0;
    w1 = (q_la.size() > bl + 1) ? q_la[bl+1] : '0;
    checks++; if (w0 !== 32'h00CCBBAA) begin errors++; $display("FAIL coinc_flush_word: got %h want 00ccbbaa", w0); end
    checks++; if (w1 !== 32'h11FFEEDD) begin errors++; $display("FAIL coinc_next_group: got %h want 11ffeedd", w1); end
    checks++; if (((t_la.size() > bl) ? t_la[bl] : -1) != st + 4) begin errors++; $display("FAIL coinc_lat: got %0d want %0d", (t_la.size() > bl) ? t_la[bl] - st : -1, 4); end
  endtask

  task automatic test_reset_mid();
    int bl, st;
    logic [OW-1:0] w0;
    do_reset();
    for (int i = 0; i < 6; i++) src[i] = DW'(i + 1);
    full = 1'b1;
    src_len = 6;
    rst = 1'b0;
    step(10);
    checks++; if (wr_la !== 1'b1) begin errors++; $display("FAIL rstmid_held_wr: got %b want 1", wr_la); end
    bl = q_la.size();
    rst = 1'b1;
    step(1);
    checks++; if (wr_la !== 1'b0) begin errors++; $display("FAIL rstmid_wr: got %b want 0", wr_la); end
    checks++; if (din_la !== '0) begin errors++; $display("FAIL rstmid_din: got %h want 0", din_la); end
    for (int i = 0; i < 4; i++) src[i] = DW'(8'h11 + i);
    src_len = 4;
    full = 1'b0;
    rst = 1'b0;
    st = cyc;
    step(8);
    checks++; if (q_la.size() - bl != 1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", q_la.size() - bl); end
    w0 = (q_la.size() > bl) ? q_la[bl] : '0;
    checks++; if (w0 !== 32'h14131211) begin errors++; $display("FAIL rstmid_word: got %h want 14131211", w0); end
    checks++; if (((t_la.size() > bl) ? t_la[bl] : -1) != st + 4) begin errors++; $display("FAIL rstmid_lat: got %0d want %0d", (t_la.size() > bl) ? t_la[bl] - st : -1, 4); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    full = 1'b0;
    flush = 1'b0;
    src_len = 0;
    for (int i = 0; i < 64; i++) src[i] = '0;
    test_reset();
    test_stream();
    test_full();
    test_flush();
    test_flush_coincident();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
